// File: rtl/seq_divider_param.sv
// Multi-cycle restoring shift-subtract divider, one quotient bit per clock.
// Handles signed or unsigned operands per operation and flags divide-by-zero and signed overflow.
module seq_divider_param #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIN
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dvs;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_dbz;
    logic             r_ovf;
    logic             r_ready;
    logic             r_done;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_div_by_zero;
    logic             r_overflow;

    logic             w_dvd_neg;
    logic             w_dvs_neg;
    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;
    logic             w_dvs_zero;
    logic             w_ovf;
    logic [WIDTH:0]   w_trial;
    logic             w_ge;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_q_fix;
    logic [WIDTH-1:0] w_r_fix;

    // Negating the most-negative value yields 100..0, which read as unsigned is exactly 2^(WIDTH-1).
    assign w_dvd_neg  = signed_mode & dividend[WIDTH-1];
    assign w_dvs_neg  = signed_mode & divisor[WIDTH-1];
    assign w_dvd_mag  = w_dvd_neg ? -dividend : dividend;
    assign w_dvs_mag  = w_dvs_neg ? -divisor : divisor;
    assign w_dvs_zero = (divisor == '0);
    assign w_ovf      = signed_mode && (dividend == MOST_NEG) && (divisor == '1);

    // r_q starts as the dividend magnitude; its MSB feeds the remainder while quotient bits enter at the LSB.
    assign w_trial = {r_rem, r_q[WIDTH-1]};
    assign w_ge    = (w_trial >= {1'b0, r_dvs});
    assign w_diff  = w_trial[WIDTH-1:0] - r_dvs;

    assign w_q_fix = r_neg_q ? -r_q : r_q;
    assign w_r_fix = r_neg_r ? -r_rem : r_rem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_q           <= '0;
            r_rem         <= '0;
            r_dvs         <= '0;
            r_neg_q       <= 1'b0;
            r_neg_r       <= 1'b0;
            r_dbz         <= 1'b0;
            r_ovf         <= 1'b0;
            r_ready       <= 1'b1;
            r_done        <= 1'b0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && r_ready) begin
                        r_neg_q <= w_dvd_neg ^ w_dvs_neg;
                        r_neg_r <= w_dvd_neg;
                        r_dbz   <= w_dvs_zero;
                        r_ovf   <= w_ovf;
                        r_dvs   <= w_dvs_mag;
                        r_rem   <= '0;
                        r_cnt   <= '0;
                        r_ready <= 1'b0;
                        // Divide-by-zero skips the iterations and keeps the raw dividend for the remainder.
                        if (w_dvs_zero) begin
                            r_q     <= dividend;
                            r_state <= S_FIN;
                        end else begin
                            r_q     <= w_dvd_mag;
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    r_rem <= w_ge ? w_diff : w_trial[WIDTH-1:0];
                    r_q   <= {r_q[WIDTH-2:0], w_ge};
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        r_state <= S_FIN;
                    end
                end
                S_FIN: begin
                    r_done        <= 1'b1;
                    r_ready       <= 1'b1;
                    r_state       <= S_IDLE;
                    r_div_by_zero <= r_dbz;
                    r_overflow    <= r_ovf;
                    if (r_dbz) begin
                        r_quotient  <= '1;
                        r_remainder <= r_q;
                    end else begin
                        r_quotient  <= w_q_fix;
                        r_remainder <= w_r_fix;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign ready       = r_ready;
    assign done        = r_done;
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_div_by_zero;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_seq_divider_param.sv
// Self-checking bench for seq_divider_param at WIDTH=8 and WIDTH=16.
// Directed cases use hand-derived constants; the random sweep uses an integer reference model.
module tb_seq_divider_param;

    logic clk;
    logic rst;

    logic        s8_start, s8_sm;
    logic [7:0]  s8_a, s8_b;
    logic        o8_ready, o8_done, o8_dz, o8_ov;
    logic [7:0]  o8_q, o8_r;

    logic        s16_start, s16_sm;
    logic [15:0] s16_a, s16_b;
    logic        o16_ready, o16_done, o16_dz, o16_ov;
    logic [15:0] o16_q, o16_r;

    int n_checks = 0;
    int n_pass   = 0;

    seq_divider_param #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(s8_start), .signed_mode(s8_sm),
        .dividend(s8_a), .divisor(s8_b), .ready(o8_ready), .done(o8_done),
        .quotient(o8_q), .remainder(o8_r), .div_by_zero(o8_dz), .overflow(o8_ov)
    );

    seq_divider_param #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(s16_start), .signed_mode(s16_sm),
        .dividend(s16_a), .divisor(s16_b), .ready(o16_ready), .done(o16_done),
        .quotient(o16_q), .remainder(o16_r), .div_by_zero(o16_dz), .overflow(o16_ov)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {quotient, remainder, div_by_zero, overflow} from plain integer arithmetic.
    function automatic logic [17:0] ref8(input logic sm, input logic [7:0] a, input logic [7:0] b);
        int sa, sb;
        logic [7:0] q, r;
        logic dz, ov;
        dz = 1'b0;
        ov = 1'b0;
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (b == 8'd0) begin
            q = 8'hFF; r = a; dz = 1'b1;
        end else if (sm) begin
            if (sa == -128 && sb == -1) begin
                q = 8'h80; r = 8'h00; ov = 1'b1;
            end else begin
                q = 8'(sa / sb);
                r = 8'(sa % sb);
            end
        end else begin
            q = a / b;
            r = a % b;
        end
        return {q, r, dz, ov};
    endfunction

    task automatic issue8(input logic sm, input logic [7:0] a, input logic [7:0] b);
        s8_sm = sm; s8_a = a; s8_b = b; s8_start = 1'b1;
        @(posedge clk); #1;
        s8_start = 1'b0;
    endtask

    task automatic wait_done8(output int lat);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!o8_done && lat < 50);
    endtask

    task automatic issue16(input logic sm, input logic [15:0] a, input logic [15:0] b);
        s16_sm = sm; s16_a = a; s16_b = b; s16_start = 1'b1;
        @(posedge clk); #1;
        s16_start = 1'b0;
    endtask

    task automatic wait_done16(output int lat);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!o16_done && lat < 80);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({o8_ready, o8_done, o8_q, o8_r, o8_dz, o8_ov} !== {1'b1, 1'b0, 18'd0})
            $display("FAIL reset8 got rdy=%b done=%b q=%h r=%h dz=%b ov=%b want rdy=1 rest 0",
                     o8_ready, o8_done, o8_q, o8_r, o8_dz, o8_ov);
        else n_pass++;
        n_checks++;
        if ({o16_ready, o16_done, o16_q, o16_r, o16_dz, o16_ov} !== {1'b1, 1'b0, 34'd0})
            $display("FAIL reset16 got rdy=%b done=%b q=%h r=%h want rdy=1 rest 0",
                     o16_ready, o16_done, o16_q, o16_r);
        else n_pass++;
        rst = 1'b0;
        $display("reset: outputs checked after reset");
    endtask

    task automatic test_unsigned();
        logic [7:0] ta [2] = '{8'd200, 8'd255};
        logic [7:0] tb [2] = '{8'd7,   8'd1};
        logic [7:0] tq [2] = '{8'd28,  8'd255};
        logic [7:0] tr [2] = '{8'd4,   8'd0};
        int lat;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            issue8(1'b0, ta[i], tb[i]);
            wait_done8(lat);
            n_checks++;
            if (lat !== 9) $display("FAIL unsigned_latency[%0d] got %0d want 9", i, lat);
            else n_pass++;
            n_checks++;
            if ({o8_q, o8_r, o8_dz, o8_ov, o8_ready} !== {tq[i], tr[i], 1'b0, 1'b0, 1'b1})
                $display("FAIL unsigned_result[%0d] got q=%0d r=%0d dz=%b ov=%b rdy=%b want q=%0d r=%0d flags 0 rdy 1",
                         i, o8_q, o8_r, o8_dz, o8_ov, o8_ready, tq[i], tr[i]);
            else n_pass++;
            $display("unsigned %0d/%0d -> q=%0d r=%0d lat=%0d", ta[i], tb[i], o8_q, o8_r, lat);
        end
    endtask

    task automatic test_signed();
        logic [7:0] ta [3] = '{8'h9C, 8'h64, 8'h9C};
        logic [7:0] tb [3] = '{8'h07, 8'hF9, 8'hF9};
        logic [7:0] tq [3] = '{8'hF2, 8'hF2, 8'h0E};
        logic [7:0] tr [3] = '{8'hFE, 8'h02, 8'hFE};
        int lat;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            issue8(1'b1, ta[i], tb[i]);
            wait_done8(lat);
            n_checks++;
            if ({o8_q, o8_r, o8_dz, o8_ov} !== {tq[i], tr[i], 2'b00} || lat !== 9)
                $display("FAIL signed[%0d] got q=%h r=%h dz=%b ov=%b lat=%0d want q=%h r=%h flags 0 lat 9",
                         i, o8_q, o8_r, o8_dz, o8_ov, lat, tq[i], tr[i]);
            else n_pass++;
            $display("signed %h/%h -> q=%h r=%h lat=%0d", ta[i], tb[i], o8_q, o8_r, lat);
        end
    endtask

    task automatic test_div_zero();
        int lat;
        @(negedge clk);
        issue8(1'b0, 8'd55, 8'd0);
        wait_done8(lat);
        n_checks++;
        if ({o8_q, o8_r, o8_dz, o8_ov} !== {8'hFF, 8'd55, 2'b10} || lat !== 1)
            $display("FAIL divzero got q=%h r=%0d dz=%b ov=%b lat=%0d want q=ff r=55 dz=1 ov=0 lat=1",
                     o8_q, o8_r, o8_dz, o8_ov, lat);
        else n_pass++;
        $display("divzero 55/0 -> q=%h r=%0d dz=%b lat=%0d", o8_q, o8_r, o8_dz, lat);
        @(negedge clk);
        issue8(1'b1, 8'hFB, 8'd0);
        wait_done8(lat);
        n_checks++;
        if ({o8_q, o8_r, o8_dz, o8_ov} !== {8'hFF, 8'hFB, 2'b10} || lat !== 1)
            $display("FAIL divzero_signed got q=%h r=%h dz=%b lat=%0d want q=ff r=fb dz=1 lat=1",
                     o8_q, o8_r, o8_dz, lat);
        else n_pass++;
        $display("divzero signed fb/0 -> q=%h r=%h dz=%b lat=%0d", o8_q, o8_r, o8_dz, lat);
        @(negedge clk);
        issue8(1'b0, 8'd10, 8'd3);
        wait_done8(lat);
        n_checks++;
        if ({o8_q, o8_r, o8_dz, o8_ov} !== {8'd3, 8'd1, 2'b00} || lat !== 9)
            $display("FAIL divzero_clear got q=%0d r=%0d dz=%b lat=%0d want q=3 r=1 dz=0 lat=9",
                     o8_q, o8_r, o8_dz, lat);
        else n_pass++;
        $display("after divzero 10/3 -> q=%0d r=%0d dz=%b", o8_q, o8_r, o8_dz);
    endtask

    task automatic test_overflow();
        int lat;
        @(negedge clk);
        issue8(1'b1, 8'h80, 8'hFF);
        wait_done8(lat);
        n_checks++;
        if ({o8_q, o8_r, o8_dz, o8_ov} !== {8'h80, 8'h00, 2'b01} || lat !== 9)
            $display("FAIL overflow_signed got q=%h r=%h dz=%b ov=%b lat=%0d want q=80 r=00 ov=1 lat=9",
                     o8_q, o8_r, o8_dz, o8_ov, lat);
        else n_pass++;
        $display("overflow signed 80/ff -> q=%h r=%h ov=%b", o8_q, o8_r, o8_ov);
        @(negedge clk);
        issue8(1'b0, 8'h80, 8'hFF);
        wait_done8(lat);
        n_checks++;
        if ({o8_q, o8_r, o8_dz, o8_ov} !== {8'h00, 8'h80, 2'b00})
            $display("FAIL overflow_unsigned got q=%h r=%h ov=%b want q=00 r=80 ov=0",
                     o8_q, o8_r, o8_ov);
        else n_pass++;
        $display("unsigned 128/255 -> q=%h r=%h ov=%b", o8_q, o8_r, o8_ov);
    endtask

    task automatic test_busy_ignore();
        int lat;
        int n_done;
        @(negedge clk);
        issue8(1'b0, 8'd100, 8'd9);
        s8_sm = 1'b1; s8_a = 8'd7; s8_b = 8'd2; s8_start = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        s8_start = 1'b0;
        wait_done8(lat);
        n_checks++;
        if ({o8_q, o8_r, o8_dz, o8_ov} !== {8'd11, 8'd1, 2'b00} || lat + 3 !== 9)
            $display("FAIL busy_ignore got q=%0d r=%0d lat=%0d want q=11 r=1 lat=9",
                     o8_q, o8_r, lat + 3);
        else n_pass++;
        n_done = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (o8_done) n_done++;
        end
        n_checks++;
        if (n_done !== 0) $display("FAIL busy_no_queue got %0d extra done pulses want 0", n_done);
        else n_pass++;
        $display("busy ignore 100/9 -> q=%0d r=%0d extra_done=%0d", o8_q, o8_r, n_done);
    endtask

    task automatic test_reset_midcalc();
        int lat;
        int n_done;
        @(negedge clk);
        issue8(1'b0, 8'd200, 8'd7);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({o8_ready, o8_done, o8_q, o8_r, o8_dz, o8_ov} !== {1'b1, 1'b0, 18'd0})
            $display("FAIL reset_midcalc got rdy=%b done=%b q=%h r=%h dz=%b ov=%b want rdy=1 rest 0",
                     o8_ready, o8_done, o8_q, o8_r, o8_dz, o8_ov);
        else n_pass++;
        n_done = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (o8_done) n_done++;
        end
        n_checks++;
        if (n_done !== 0) $display("FAIL reset_no_done got %0d done pulses want 0", n_done);
        else n_pass++;
        @(negedge clk);
        issue8(1'b0, 8'd9, 8'd2);
        wait_done8(lat);
        n_checks++;
        if ({o8_q, o8_r, o8_dz, o8_ov} !== {8'd4, 8'd1, 2'b00} || lat !== 9)
            $display("FAIL reset_fresh got q=%0d r=%0d lat=%0d want q=4 r=1 lat=9", o8_q, o8_r, lat);
        else n_pass++;
        $display("reset mid-calc then 9/2 -> q=%0d r=%0d", o8_q, o8_r);
    endtask

    task automatic test_back_to_back();
        int lat;
        @(negedge clk);
        issue8(1'b0, 8'd200, 8'd7);
        wait_done8(lat);
        n_checks++;
        if ({o8_done, o8_ready, o8_q, o8_r} !== {1'b1, 1'b1, 8'd28, 8'd4})
            $display("FAIL b2b_first got done=%b rdy=%b q=%0d r=%0d want done=1 rdy=1 q=28 r=4",
                     o8_done, o8_ready, o8_q, o8_r);
        else n_pass++;
        issue8(1'b1, 8'h9C, 8'h07);
        n_checks++;
        if ({o8_ready, o8_done} !== 2'b00)
            $display("FAIL b2b_accept got rdy=%b done=%b want rdy=0 done=0", o8_ready, o8_done);
        else n_pass++;
        wait_done8(lat);
        n_checks++;
        if ({o8_q, o8_r} !== {8'hF2, 8'hFE} || lat !== 9)
            $display("FAIL b2b_second got q=%h r=%h lat=%0d want q=f2 r=fe lat=9", o8_q, o8_r, lat);
        else n_pass++;
        $display("back-to-back second op -> q=%h r=%h lat=%0d", o8_q, o8_r, lat);
    endtask

    task automatic test_width16();
        int lat;
        @(negedge clk);
        issue16(1'b0, 16'd50000, 16'd123);
        wait_done16(lat);
        n_checks++;
        if ({o16_q, o16_r, o16_dz, o16_ov} !== {16'd406, 16'd62, 2'b00} || lat !== 17)
            $display("FAIL width16 got q=%0d r=%0d dz=%b ov=%b lat=%0d want q=406 r=62 lat=17",
                     o16_q, o16_r, o16_dz, o16_ov, lat);
        else n_pass++;
        $display("width16 50000/123 -> q=%0d r=%0d lat=%0d", o16_q, o16_r, lat);
        @(negedge clk);
        issue16(1'b1, 16'h8AD0, 16'd7);
        wait_done16(lat);
        n_checks++;
        if ({o16_q, o16_r} !== {16'hEF43, 16'hFFFB} || lat !== 17)
            $display("FAIL width16_signed got q=%h r=%h lat=%0d want q=ef43 r=fffb lat=17",
                     o16_q, o16_r, lat);
        else n_pass++;
        $display("width16 -30000/7 -> q=%h r=%h lat=%0d", o16_q, o16_r, lat);
        @(negedge clk);
        issue16(1'b0, 16'd1234, 16'd0);
        wait_done16(lat);
        n_checks++;
        if ({o16_q, o16_r, o16_dz} !== {16'hFFFF, 16'd1234, 1'b1} || lat !== 1)
            $display("FAIL width16_divzero got q=%h r=%0d dz=%b lat=%0d want q=ffff r=1234 dz=1 lat=1",
                     o16_q, o16_r, o16_dz, lat);
        else n_pass++;
        $display("width16 1234/0 -> q=%h r=%0d dz=%b", o16_q, o16_r, o16_dz);
    endtask

    task automatic test_random();
        int lat, want_lat;
        logic sm;
        logic [7:0] a, b;
        logic [17:0] exp;
        int sa, sb, sq, sr;
        for (int i = 0; i < 60; i++) begin
            sm = 1'($urandom_range(0, 1));
            a  = 8'($urandom);
            b  = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom);
            if ($urandom_range(0, 15) == 0) begin
                a = 8'h80; b = 8'hFF;
            end
            exp = ref8(sm, a, b);
            want_lat = (b == 8'd0) ? 1 : 9;
            @(negedge clk);
            issue8(sm, a, b);
            wait_done8(lat);
            n_checks++;
            if ({o8_q, o8_r, o8_dz, o8_ov} !== exp || lat !== want_lat)
                $display("FAIL random[%0d] sm=%b %h/%h got q=%h r=%h dz=%b ov=%b lat=%0d want q=%h r=%h dz=%b ov=%b lat=%0d",
                         i, sm, a, b, o8_q, o8_r, o8_dz, o8_ov, lat,
                         exp[17:10], exp[9:2], exp[1], exp[0], want_lat);
            else n_pass++;
            if (b != 8'd0 && !exp[0]) begin
                if (sm) begin
                    sa = int'($signed(a)); sb = int'($signed(b));
                    sq = int'($signed(o8_q)); sr = int'($signed(o8_r));
                end else begin
                    sa = int'(a); sb = int'(b); sq = int'(o8_q); sr = int'(o8_r);
                end
                n_checks++;
                if (sa != sq * sb + sr || (sr < 0 ? -sr : sr) >= (sb < 0 ? -sb : sb))
                    $display("FAIL invariant[%0d] %0d != %0d*%0d+%0d or |r| too large", i, sa, sq, sb, sr);
                else n_pass++;
            end
            $display("random[%0d] sm=%b %h/%h -> q=%h r=%h dz=%b ov=%b", i, sm, a, b, o8_q, o8_r, o8_dz, o8_ov);
        end
    endtask

    initial begin
        s8_start = 1'b0; s8_sm = 1'b0; s8_a = '0; s8_b = '0;
        s16_start = 1'b0; s16_sm = 1'b0; s16_a = '0; s16_b = '0;
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_busy_ignore();
        test_reset_midcalc();
        test_back_to_back();
        test_width16();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seq_divider_param.md
Name: seq_divider_param

Overview:
- Parametrised, multi-cycle successor to the team's combinational 8-bit repeated-subtraction divider.
- Computes one quotient bit per clock using restoring shift-subtract.
- Supports signed or unsigned operation per operation, with a start/done handshake.
- Flags divide-by-zero and signed overflow; used as the shared divide unit in the arithmetic datapath.

Parameters:
- WIDTH, 8, operand and result width in bits (>= 2).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; accepted only when ready=1
- signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled at accept
- dividend  input  WIDTH  numerator, sampled at accept
- divisor  input  WIDTH  denominator, sampled at accept
- ready  output  1  high when idle and able to accept start
- done  output  1  one-cycle pulse; results valid from this cycle
- quotient  output  WIDTH  registered quotient, held until next done
- remainder  output  WIDTH  registered remainder, held until next done
- div_by_zero  output  1  registered with results; divisor was 0
- overflow  output  1  registered with results; signed most-negative / -1

Behaviour:
- Reset (async, any state): state=IDLE, ready=1, done=0, quotient=0, remainder=0, div_by_zero=0, overflow=0, internal counter and working registers cleared.
- An in-flight operation is abandoned on reset; no done is produced.
- Accept: rising edge with start=1 and ready=1. Operands and signed_mode are latched at that edge, and ready drops in the following cycle.
- start while ready=0 is ignored, with no queuing.
- States:
  - IDLE -> (accept, divisor!=0) CALC; (accept, divisor==0) FIN.
  - CALC: runs WIDTH cycles, each shifting the partial remainder left by one with the next dividend bit. If the partial remainder >= |divisor|, subtract and set the quotient bit to 1. Then -> FIN.
  - FIN: apply sign correction, register the outputs, pulse done=1, and -> IDLE (ready=1 in the same cycle as done).
- Latency:
  - Normal case: done is high in the cycle after edge WIDTH+1 counted from the accepting edge (accept = edge 0), i.e. WIDTH+1 edges later.
  - Divide-by-zero: done follows 1 edge after accept.
  - A new start may be accepted in the done cycle.
- Arithmetic width:
  - Internal magnitudes use WIDTH bits, with a WIDTH+1-bit partial remainder for the compare.
  - In signed mode, magnitudes are taken as |x|, and |most-negative| is represented correctly as unsigned 2^(WIDTH-1).
- Signed rules:
  - The quotient truncates toward zero and is negated when the operand signs differ.
  - The remainder takes the sign of the dividend.
  - Invariant: dividend = quotient*divisor + remainder, with |remainder| < |divisor|.
- Unsigned mode: plain unsigned quotient/remainder, no sign correction, and overflow is always 0.
- Divide-by-zero: quotient = all ones, remainder = dividend unchanged, div_by_zero=1, overflow=0.
- Signed overflow (dividend = 100..0, divisor = all ones, signed_mode=1): quotient = 100..0 (wrapped), remainder=0, overflow=1.
- div_by_zero and overflow are updated at every done and held otherwise.
- quotient and remainder change only in the done cycle. They never show intermediate values.

Test Plan:
- Unsigned, WIDTH=8: 200/7 -> after 9 edges done=1, quotient=28, remainder=4, flags 0; ready high in the done cycle. Also 255/1 -> quotient=255, remainder=0.
- Signed sign correction, WIDTH=8:
  - -100/7 -> quotient=-14 (0xF2), remainder=-2 (0xFE).
  - 100/-7 -> quotient=0xF2, remainder=2.
  - -100/-7 -> quotient=14, remainder=0xFE.
- Divide-by-zero, WIDTH=8: 55/0, unsigned -> done 1 edge after accept, quotient=0xFF, remainder=55, div_by_zero=1. The next normal op 10/3 clears the flag (quotient=3, remainder=1).
- Signed overflow, WIDTH=8: -128/-1 -> quotient=0x80, remainder=0, overflow=1.
  - Same operands unsigned (128/255) -> quotient=0, remainder=128, overflow=0.
- Handshake and reset:
  - A second start with different operands while busy is ignored; the results match the first op only.
  - Assert rst mid-CALC: all outputs read 0 and ready=1 immediately, no done pulse.
  - A fresh 9/2 after reset gives quotient=4, remainder=1.
- Back-to-back and parametric:
  - A start asserted in the done cycle is accepted, with no lost cycle.
  - Rerun at WIDTH=16: 50000/123 -> quotient=406, remainder=62 after 17 edges.
  - Random signed/unsigned sweep checks the invariant against a reference model.
